// File: rtl/seg7_scan_decoder.sv
// Loopback monitor for a multiplexed 4-digit seven-segment display: recovers HH:MM digits from the active-low scan lines.
// Optional SEG7_DEC_STATS_EN adds err_count / frame_count statistics outputs.
module seg7_scan_decoder #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 200_000,
   parameter int TMR_W          = 18
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic [0:6] seg,
   input  logic [3:0] an,
   output logic [2:0] hrs_tens,
   output logic [3:0] hrs_ones,
   output logic [2:0] mins_tens,
   output logic [3:0] mins_ones,
   output logic [3:0] digit_valid,
   output logic       frame_valid,
   output logic       frame_done,
   output logic       decode_err,
   output logic       scan_stall
`ifdef SEG7_DEC_STATS_EN
   ,
   output logic [7:0]  err_count,
   output logic [15:0] frame_count
`endif
);

   localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMO_MAX     = TMR_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t           state;
   logic [0:6]       seg_meta, s_seg, seg_prev;
   logic [3:0]       an_meta, s_an, an_prev;
   logic [TMR_W-1:0] settle_cnt, tmo_cnt;
   logic             an_chg, seg_chg, timeout_hit;
   logic             pos_ok;
   logic [1:0]       pos;
   logic             seg_blank, seg_digit;
   logic [3:0]       seg_val;
   logic             pat_legal;
   logic             capture_fire;
   logic [3:0]       valid_next;

   // Two-flop synchronizers plus a history stage; idle lines are all-high.
   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         seg_meta <= '1;
         s_seg    <= '1;
         seg_prev <= '1;
         an_meta  <= '1;
         s_an     <= '1;
         an_prev  <= '1;
      end else begin
         seg_meta <= seg;
         s_seg    <= seg_meta;
         seg_prev <= s_seg;
         an_meta  <= an;
         s_an     <= an_meta;
         an_prev  <= s_an;
      end
   end

   assign an_chg      = (s_an != an_prev);
   assign seg_chg     = (s_seg != seg_prev);
   assign timeout_hit = !an_chg && (tmo_cnt == TMO_LAST);

   always_comb begin
      seg_blank = 1'b0;
      seg_digit = 1'b1;
      seg_val   = 4'd0;
      case (s_seg)
         7'b1111111: begin seg_blank = 1'b1; seg_digit = 1'b0; end
         7'b0000001: seg_val = 4'd0;
         7'b1001111: seg_val = 4'd1;
         7'b0010010: seg_val = 4'd2;
         7'b0000110: seg_val = 4'd3;
         7'b1001100: seg_val = 4'd4;
         7'b0100100: seg_val = 4'd5;
         7'b0100000: seg_val = 4'd6;
         7'b0001111: seg_val = 4'd7;
         7'b0000000: seg_val = 4'd8;
         7'b0000100: seg_val = 4'd9;
         default:    seg_digit = 1'b0;
      endcase
   end

   // pos 3 = hrs_tens ... pos 0 = mins_ones, matching digit_valid bit order.
   always_comb begin
      pos_ok = 1'b1;
      pos    = 2'd0;
      case (s_an)
         4'b0111: pos = 2'd3;
         4'b1011: pos = 2'd2;
         4'b1101: pos = 2'd1;
         4'b1110: pos = 2'd0;
         default: pos_ok = 1'b0;
      endcase
   end

   // A blank leading hours digit reads as zero; seg_val is already 0 for blank.
   always_comb begin
      case (pos)
         2'd3:    pat_legal = seg_blank || (seg_digit && (seg_val == 4'd1));
         2'd1:    pat_legal = seg_digit && (seg_val <= 4'd5);
         default: pat_legal = seg_digit;
      endcase
   end

   assign capture_fire = (state == SETTLE) && pos_ok && !an_chg && !seg_chg &&
                         (settle_cnt == SETTLE_LAST) && !timeout_hit;

   always_comb begin
      valid_next = digit_valid;
      if (timeout_hit)
         valid_next = 4'b0000;
      else if (capture_fire)
         valid_next[pos] = pat_legal;
   end

   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         tmo_cnt     <= '0;
         hrs_tens    <= '0;
         hrs_ones    <= '0;
         mins_tens   <= '0;
         mins_ones   <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         frame_done  <= 1'b0;
         decode_err  <= 1'b0;
         scan_stall  <= 1'b0;
      end else begin
         digit_valid <= valid_next;
         frame_valid <= &valid_next;
         decode_err  <= capture_fire && !pat_legal;
         frame_done  <= capture_fire && pat_legal && (pos == 2'd0) && (&valid_next);

         if (capture_fire && pat_legal) begin
            case (pos)
               2'd3:    hrs_tens  <= seg_val[2:0];
               2'd2:    hrs_ones  <= seg_val;
               2'd1:    mins_tens <= seg_val[2:0];
               default: mins_ones <= seg_val;
            endcase
         end

         // Stall watchdog saturates after firing so it triggers once per stall.
         if (an_chg) begin
            tmo_cnt    <= '0;
            scan_stall <= 1'b0;
         end else if (timeout_hit) begin
            tmo_cnt    <= TMO_MAX;
            scan_stall <= 1'b1;
         end else if (tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end

         if (timeout_hit) begin
            state      <= IDLE;
            settle_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  // While stalled, wait for fresh anode activity before capturing again.
                  if (pos_ok && (!scan_stall || an_chg)) begin
                     state      <= SETTLE;
                     settle_cnt <= '0;
                  end
               end
               SETTLE: begin
                  if (!pos_ok)
                     state <= IDLE;
                  else if (an_chg || seg_chg)
                     settle_cnt <= '0;
                  else if (settle_cnt == SETTLE_LAST)
                     state <= HOLD;
                  else
                     settle_cnt <= settle_cnt + 1'b1;
               end
               HOLD: begin
                  if (an_chg) begin
                     state      <= pos_ok ? SETTLE : IDLE;
                     settle_cnt <= '0;
                  end else if (seg_chg) begin
                     state      <= SETTLE;
                     settle_cnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef SEG7_DEC_STATS_EN
   always_ff @(posedge clk_100Mhz or posedge reset) begin
      if (reset) begin
         err_count   <= '0;
         frame_count <= '0;
      end else begin
         if (decode_err && (err_count != 8'hFF))
            err_count <= err_count + 1'b1;
         if (frame_done)
            frame_count <= frame_count + 1'b1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule
